// File: rtl/mips_ctrl.sv
// Main control decoder for the MIPS ID stage: decodes op/func into datapath
// controls and registers them into the ID/EX segment with reset and stall hold.
module mips_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic [4:0] shamt,
  input  logic [5:0] func,
  output logic       RegDst,
  output logic       RegWr,
  output logic       ALUSrc,
  output logic       MemWr,
  output logic       MemtoReg,
  output logic [1:0] ExtOp,
  output logic [4:0] ALUctr,
  output logic       Branch,
  output logic       Jump
);

  localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_ADDU = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010, ALU_SUBU = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00100, ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110, ALU_NOR  = 5'b00111;
  localparam logic [4:0] ALU_SLT  = 5'b01000, ALU_SLTU = 5'b01001;
  localparam logic [4:0] ALU_SLL  = 5'b01010, ALU_SRL  = 5'b01011;
  localparam logic [4:0] ALU_SRA  = 5'b01100, ALU_SLLV = 5'b01101;
  localparam logic [4:0] ALU_SRLV = 5'b01110, ALU_SRAV = 5'b01111;
  localparam logic [4:0] ALU_LUI  = 5'b10000;

  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_HIGH = 2'b10;

  logic       regdst_d, regwr_d, alusrc_d, memwr_d, memtoreg_d, branch_d, jump_d;
  logic [1:0] extop_d;
  logic [4:0] aluctr_d;
  logic       regdst_q, regwr_q, alusrc_q, memwr_q, memtoreg_q, branch_q, jump_q;
  logic [1:0] extop_q;
  logic [4:0] aluctr_q;

  logic       r_ok;
  logic [4:0] r_alu;
  logic       i_arith;

  // rs and shamt are routed to the datapath directly and play no part in decode
  logic unused_fields;
  assign unused_fields = ^{rs, shamt};

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (func)
      6'b000000: r_alu = ALU_SLL;
      6'b000010: r_alu = ALU_SRL;
      6'b000011: r_alu = ALU_SRA;
      6'b000100: r_alu = ALU_SLLV;
      6'b000110: r_alu = ALU_SRLV;
      6'b000111: r_alu = ALU_SRAV;
      6'b100000: r_alu = ALU_ADD;
      6'b100001: r_alu = ALU_ADDU;
      6'b100010: r_alu = ALU_SUB;
      6'b100011: r_alu = ALU_SUBU;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100110: r_alu = ALU_XOR;
      6'b100111: r_alu = ALU_NOR;
      6'b101010: r_alu = ALU_SLT;
      6'b101011: r_alu = ALU_SLTU;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    regdst_d   = 1'b0;
    regwr_d    = 1'b0;
    alusrc_d   = 1'b0;
    memwr_d    = 1'b0;
    memtoreg_d = 1'b0;
    extop_d    = EXT_ZERO;
    aluctr_d   = ALU_ADD;
    branch_d   = 1'b0;
    jump_d     = 1'b0;
    i_arith    = 1'b0;
    case (op)
      6'b000000: if (r_ok) begin
        regdst_d = 1'b1;
        regwr_d  = (rd != 5'd0);
        aluctr_d = r_alu;
      end
      6'b001000: begin i_arith = 1'b1; extop_d = EXT_SIGN; aluctr_d = ALU_ADD;  end
      6'b001001: begin i_arith = 1'b1; extop_d = EXT_SIGN; aluctr_d = ALU_ADDU; end
      6'b001010: begin i_arith = 1'b1; extop_d = EXT_SIGN; aluctr_d = ALU_SLT;  end
      6'b001011: begin i_arith = 1'b1; extop_d = EXT_SIGN; aluctr_d = ALU_SLTU; end
      6'b001100: begin i_arith = 1'b1; extop_d = EXT_ZERO; aluctr_d = ALU_AND;  end
      6'b001101: begin i_arith = 1'b1; extop_d = EXT_ZERO; aluctr_d = ALU_OR;   end
      6'b001110: begin i_arith = 1'b1; extop_d = EXT_ZERO; aluctr_d = ALU_XOR;  end
      6'b001111: begin i_arith = 1'b1; extop_d = EXT_HIGH; aluctr_d = ALU_LUI;  end
      6'b100011: begin
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
        regwr_d    = (rt != 5'd0);
        extop_d    = EXT_SIGN;
        aluctr_d   = ALU_ADDU;
      end
      6'b101011: begin
        alusrc_d = 1'b1;
        memwr_d  = 1'b1;
        extop_d  = EXT_SIGN;
        aluctr_d = ALU_ADDU;
      end
      6'b000100, 6'b000101: begin
        branch_d = 1'b1;
        extop_d  = EXT_SIGN;
        aluctr_d = ALU_SUBU;
      end
      6'b000010: jump_d = 1'b1;
      default: ;
    endcase
    if (i_arith) begin
      alusrc_d = 1'b1;
      regwr_d  = (rt != 5'd0);
    end
  end

  // Reset inserts a bubble; en low freezes the ID/EX controls during a stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regdst_q   <= 1'b0;
      regwr_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      memwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      extop_q    <= 2'b00;
      aluctr_q   <= 5'b00000;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
    end else if (en) begin
      regdst_q   <= regdst_d;
      regwr_q    <= regwr_d;
      alusrc_q   <= alusrc_d;
      memwr_q    <= memwr_d;
      memtoreg_q <= memtoreg_d;
      extop_q    <= extop_d;
      aluctr_q   <= aluctr_d;
      branch_q   <= branch_d;
      jump_q     <= jump_d;
    end
  end

  assign RegDst   = regdst_q;
  assign RegWr    = regwr_q;
  assign ALUSrc   = alusrc_q;
  assign MemWr    = memwr_q;
  assign MemtoReg = memtoreg_q;
  assign ExtOp    = extop_q;
  assign ALUctr   = aluctr_q;
  assign Branch   = branch_q;
  assign Jump     = jump_q;

endmodule

// File: tb/tb_mips_ctrl.sv
// Bench for mips_ctrl: table-driven reference decoder with a per-cycle compare,
// directed literal checks, then randomized instructions, resets and stalls.
module tb_mips_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd, shamt;
  logic       RegDst, RegWr, ALUSrc, MemWr, MemtoReg, Branch, Jump;
  logic [1:0] ExtOp;
  logic [4:0] ALUctr;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int rtab [64];
  int itab_alu [64];
  int itab_ext [64];

  logic [14:0] exp_q;

  mips_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .func(func), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc(ALUSrc),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUctr(ALUctr),
    .Branch(Branch), .Jump(Jump)
  );

  always #5 clk = ~clk;

  // Output word layout: {RegDst,RegWr,ALUSrc,MemWr,MemtoReg,ExtOp,ALUctr,Branch,Jump}
  function automatic logic [14:0] pack(input bit dst, input bit wr, input bit src,
                                       input bit mw, input bit m2r, input int ext,
                                       input int alu, input bit br, input bit jp);
    logic [1:0] e;
    logic [4:0] a;
    e = ext[1:0];
    a = alu[4:0];
    return {dst, wr, src, mw, m2r, e, a, br, jp};
  endfunction

  function automatic logic [14:0] model(input logic [5:0] o, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    if (o == 6'd0)
      return (rtab[f] < 0) ? 15'd0 : pack(1, d != 0, 0, 0, 0, 0, rtab[f], 0, 0);
    if (itab_alu[o] >= 0)
      return pack(0, t != 0, 1, 0, 0, itab_ext[o], itab_alu[o], 0, 0);
    if (o == 6'h23) return pack(0, t != 0, 1, 0, 1, 1, 1, 0, 0);
    if (o == 6'h2b) return pack(0, 0, 1, 1, 0, 1, 1, 0, 0);
    if (o == 6'h04 || o == 6'h05) return pack(0, 0, 0, 0, 0, 1, 3, 1, 0);
    if (o == 6'h02) return pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
    return 15'd0;
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (op=%b func=%b rt=%0d rd=%0d)",
               name, act, req, op, func, rt, rd);
    end
  endtask

  function automatic logic [14:0] dut_word();
    return {RegDst, RegWr, ALUSrc, MemWr, MemtoReg, ExtOp, ALUctr, Branch, Jump};
  endfunction

  initial begin
    int r_funcs [16] = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o06, 6'o07, 6'h20, 6'h21,
                         6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    int r_alus  [16] = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int i_alus  [8]  = '{0, 1, 8, 9, 4, 5, 6, 16};
    int i_exts  [8]  = '{1, 1, 1, 1, 0, 0, 0, 2};
    for (int i = 0; i < 64; i++) begin
      rtab[i] = -1;
      itab_alu[i] = -1;
      itab_ext[i] = 0;
    end
    for (int i = 0; i < 16; i++) rtab[r_funcs[i]] = r_alus[i];
    for (int i = 0; i < 8; i++) begin
      itab_alu[8 + i] = i_alus[i];
      itab_ext[8 + i] = i_exts[i];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) exp_q <= 15'd0;
    else if (en) exp_q <= model(op, rt, rd, func);
  end

  always @(negedge clk) begin
    if (chk_on) check("cycle", dut_word(), exp_q);
  end

  task automatic apply(input bit r, input bit e, input logic [5:0] o,
                       input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    rst_n = r; en = e; op = o; rt = t; rd = d; func = f;
    rs = 5'($urandom); shamt = 5'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [14:0] LW4   = {1'b0,1'b1,1'b1,1'b0,1'b1,2'b01,5'b00001,1'b0,1'b0};
  localparam logic [14:0] ADDI2 = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,5'b00000,1'b0,1'b0};
  localparam logic [14:0] SW    = {1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,5'b00001,1'b0,1'b0};

  initial begin
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
                             6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
    logic [5:0] o, f;
    logic [4:0] t, d;

    check("model_lw", model(6'h23, 5'd4, 5'd0, 6'd0), LW4);
    check("model_sll0", model(6'd0, 5'd0, 5'd0, 6'd0),
          {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,5'b01010,1'b0,1'b0});
    check("model_bne", model(6'h05, 5'd1, 5'd2, 6'd9),
          {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,5'b00011,1'b1,1'b0});

    apply(0, 1, 6'h23, 4, 0, 0);
    chk_on = 1'b1;
    apply(0, 1, 6'h23, 4, 0, 0);
    check("reset_bubble", dut_word(), 15'd0);
    apply(1, 1, 6'h23, 4, 0, 0);
    check("lw_after_reset", dut_word(), LW4);
    apply(0, 0, 6'h23, 4, 0, 0);
    check("reset_ignores_en", dut_word(), 15'd0);

    apply(1, 1, 6'h00, 0, 5, 6'h22);
    check("sub_rd5", dut_word(), {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0});
    apply(1, 1, 6'h00, 7, 0, 6'h22);
    check("sub_rd0", dut_word(), {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,5'b00010,1'b0,1'b0});
    apply(1, 1, 6'h0d, 3, 0, 0);
    check("ori", dut_word(), {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,5'b00101,1'b0,1'b0});
    apply(1, 1, 6'h0f, 3, 0, 0);
    check("lui", dut_word(), {1'b0,1'b1,1'b1,1'b0,1'b0,2'b10,5'b10000,1'b0,1'b0});
    apply(1, 1, 6'h23, 0, 0, 0);
    check("lw_rt0", dut_word(), {1'b0,1'b0,1'b1,1'b0,1'b1,2'b01,5'b00001,1'b0,1'b0});
    apply(1, 1, 6'h2b, 6, 0, 0);
    check("sw", dut_word(), SW);
    apply(1, 1, 6'h04, 1, 2, 0);
    check("beq", dut_word(), {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,5'b00011,1'b1,1'b0});
    apply(1, 1, 6'h02, 9, 9, 6'h20);
    check("j", dut_word(), {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'b00000,1'b0,1'b1});

    apply(1, 1, 6'h08, 2, 0, 0);
    check("addi", dut_word(), ADDI2);
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 6'h2b, 6, 0, 0);
      check("stall_hold", dut_word(), ADDI2);
    end
    apply(1, 1, 6'h2b, 6, 0, 0);
    check("stall_release", dut_word(), SW);

    apply(1, 1, 6'h3f, 3, 3, 6'h20);
    check("illegal_op", dut_word(), 15'd0);
    apply(1, 1, 6'h2b, 6, 0, 0);
    apply(1, 1, 6'h00, 3, 3, 6'h08);
    check("illegal_func", dut_word(), 15'd0);

    for (int i = 0; i < 3000; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(r_pick());
      t = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      apply($urandom_range(0, 29) != 0, $urandom_range(0, 4) != 0, o, t, d, f);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int r_pick();
    int legal [16] = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o06, 6'o07, 6'h20, 6'h21,
                       6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    return legal[$urandom_range(0, 15)];
  endfunction

endmodule

// File: doc/mips_ctrl.md
Name: mips_ctrl

Overview:
- Main control decoder for the 5-stage MIPS pipeline. Sits in ID and feeds the ID/EX segment register.
- Decodes instruction fields (op, rs, rt, rd, shamt, func) into datapath control signals.
- All outputs are registered: one clock of latency, with a synchronous active-low reset and a hold (stall) enable.

Parameters:
- None.

Ports:
- clk       input   1   clock, all state updates on rising edge
- rst_n     input   1   synchronous active-low reset
- en        input   1   1 = capture new decode; 0 = hold outputs (pipeline stall)
- op        input   6   instr[31:26]
- rs        input   5   instr[25:21]; ignored by decode
- rt        input   5   instr[20:16]; I-type destination
- rd        input   5   instr[15:11]; R-type destination
- shamt     input   5   instr[10:6]; ignored by decode
- func      input   6   instr[5:0]; R-type function
- RegDst    output  1   1 = write rd, 0 = write rt
- RegWr     output  1   register-file write enable
- ALUSrc    output  1   1 = ALU B operand from extended imm16
- MemWr     output  1   data-memory write
- MemtoReg  output  1   1 = write-back from memory
- ExtOp     output  2   00 zero-ext, 01 sign-ext, 10 imm16<<16
- ALUctr    output  5   ALU operation code
- Branch    output  1   conditional branch (beq/bne)
- Jump      output  1   unconditional jump

Behaviour:
- Rising edge of clk:
  - if rst_n=0, every output is cleared to 0 (a bubble), regardless of en;
  - else if en=1, outputs take the decode of the current inputs;
  - else (en=0) outputs hold their previous values.
- Latency: exactly 1 cycle from input to output.
- ALUctr codes:
  - ADD=00000, ADDU=00001, SUB=00010, SUBU=00011
  - AND=00100, OR=00101, XOR=00110, NOR=00111
  - SLT=01000, SLTU=01001
  - SLL=01010, SRL=01011, SRA=01100, SLLV=01101, SRLV=01110, SRAV=01111
  - LUI=10000
- R-type, op=000000:
  - RegDst=1, RegWr=1, ALUSrc=0, ExtOp=00.
  - func→ALUctr: 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV, 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
  - Any other func decodes as the bubble (all outputs 0).
- Arithmetic I-type: RegDst=0, RegWr=1, ALUSrc=1.
  - addi 001000: ExtOp=01, ADD.
  - addiu 001001: ExtOp=01, ADDU.
  - slti 001010: ExtOp=01, SLT.
  - sltiu 001011: ExtOp=01, SLTU.
  - andi 001100: ExtOp=00, AND.
  - ori 001101: ExtOp=00, OR.
  - xori 001110: ExtOp=00, XOR.
  - lui 001111: ExtOp=10, LUI.
- lw 100011: ALUSrc=1, MemtoReg=1, RegWr=1, RegDst=0, ExtOp=01, ADDU.
- sw 101011: ALUSrc=1, MemWr=1, RegWr=0, ExtOp=01, ADDU.
- beq 000100 / bne 000101: Branch=1, ALUSrc=0, RegWr=0, ExtOp=01, SUBU. The downstream stage uses op to tell beq from bne.
- j 000010: Jump=1; every other output 0.
- Any unlisted opcode decodes as the bubble (all outputs 0).
- Register-0 suppression: RegWr is forced to 0 when the selected destination is 0 (rd for R-type, rt for I-type). All other outputs are unaffected. Consequently the all-zero word (sll $0,$0,0) decodes with RegWr=0.
- Only one of RegWr, MemWr, Branch, Jump can be 1 at a time; MemtoReg=1 only together with RegWr=1 or with the rt=0 suppression.
- No internal state other than the output registers.

Test Plan:
- Reset: apply rst_n=0 with en=1 and op=lw for one edge → all outputs 0 on the next cycle; release reset → lw decode appears 1 cycle later.
- R-type: op=0, func=100010, rd=5 → RegDst=1, RegWr=1, ALUSrc=0, ALUctr=00010. Same with rd=0 → RegWr=0.
- I-type: ori rt=3 → ExtOp=00, ALUctr=00101, ALUSrc=1, RegWr=1, RegDst=0. lui rt=3 → ExtOp=10, ALUctr=10000.
- Memory and control flow:
  - lw rt=4 → MemtoReg=1, RegWr=1, ExtOp=01, ALUctr=00001.
  - sw → MemWr=1, RegWr=0.
  - beq → Branch=1, ALUctr=00011.
  - j → Jump=1, all else 0.
- Stall: present addi, then hold en=0 while changing the inputs to sw for 3 cycles → outputs remain the addi decode; raise en → sw decode appears the next cycle.
- Illegal: op=111111, and op=0 with func=001000 → all outputs 0.
